// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// It produces one quotient bit per clock, and resolves divide-by-zero and signed overflow on start.
module div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             kill,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       funct3,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MinNeg = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, div_q, div_d, result_q, result_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             rem_sel_q, rem_sel_d, neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;

  logic             is_signed;
  logic [WIDTH-1:0] a_abs, b_abs, rem_it, quo_it, fin_res;
  logic [WIDTH:0]   shifted;
  logic             ge;

  // funct3[2] is always 1 for M-extension divides; only bits [1:0] select the operation.
  logic unused_funct3;
  assign unused_funct3 = funct3[2];

  assign is_signed = ~funct3[0];
  assign a_abs     = (is_signed && a[WIDTH-1]) ? -a : a;
  assign b_abs     = (is_signed && b[WIDTH-1]) ? -b : b;

  // Compare in WIDTH+1 bits; when ge holds, the difference always fits in WIDTH bits.
  assign shifted = {rem_q, quo_q[WIDTH-1]};
  assign ge      = shifted >= {1'b0, div_q};
  assign rem_it  = ge ? (shifted[WIDTH-1:0] - div_q) : shifted[WIDTH-1:0];
  assign quo_it  = {quo_q[WIDTH-2:0], ge};
  assign fin_res = rem_sel_q ? (neg_rem_q ? -rem_it : rem_it)
                             : (neg_quo_q ? -quo_it : quo_it);

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    div_d     = div_q;
    cnt_d     = cnt_q;
    rem_sel_d = rem_sel_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;
    if (kill) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          state_d = StIdle;
          if (start) begin
            rem_sel_d = funct3[1];
            neg_quo_d = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_rem_d = is_signed & a[WIDTH-1];
            div_d     = b_abs;
            if (b == '0) begin
              state_d  = StDone;
              result_d = funct3[1] ? a : '1;
            end else if (is_signed && a == MinNeg && b == '1) begin
              state_d  = StDone;
              result_d = funct3[1] ? '0 : a;
            end else begin
              state_d = StCalc;
              cnt_d   = '0;
              rem_d   = '0;
              quo_d   = a_abs;
            end
          end
        end
        StCalc: begin
          rem_d = rem_it;
          quo_d = quo_it;
          cnt_d = cnt_q + CntW'(1);
          if (cnt_q == LastCnt) begin
            state_d  = StDone;
            result_d = fin_res;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      rem_q     <= '0;
      quo_q     <= '0;
      div_q     <= '0;
      cnt_q     <= '0;
      rem_sel_q <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      div_q     <= div_d;
      cnt_q     <= cnt_d;
      rem_sel_q <= rem_sel_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
    end
  end

  assign busy   = (state_q == StCalc);
  assign done   = (state_q == StDone);
  assign result = result_q;

endmodule
